// File: rtl/syn_exec_controller.sv
// -----------------------------------------------------------------------------
// syn_exec_controller
// Debug execution controller for a soft CPU. It gates the CPU enable for
// free-running (divided), single-step and breakpoint-stopped execution, and it
// keeps retirement statistics.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_run/pause/step  single-cycle command pulses
//   div                 run-mode divisor (CPU enabled once every div+1 cycles)
//   bp_en, bp_addr      breakpoint enable and instruction address
//   pc                  current CPU PC
//   halt, is_jump,      CPU status for the current instruction
//   is_branch, branched
//   cpu_en              CPU enable (combinational), one cycle = one retire
//   state               IDLE=0, RUN=1, STEP=2, HALTED=3
//   stop_cause          NONE=0, PAUSE=1, BREAK=2, HALT=3
//   inst_cnt, jump_cnt, branch_cnt, taken_cnt   wrapping statistics counters
// -----------------------------------------------------------------------------
module syn_exec_controller #(
    parameter int unsigned DivWidth = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_run,
    input  logic                cmd_pause,
    input  logic                cmd_step,
    input  logic [DivWidth-1:0] div,
    input  logic                bp_en,
    input  logic [31:0]         bp_addr,
    input  logic [31:0]         pc,
    input  logic                halt,
    input  logic                is_jump,
    input  logic                is_branch,
    input  logic                branched,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic [1:0]          stop_cause,
    output logic [31:0]         inst_cnt,
    output logic [31:0]         jump_cnt,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         taken_cnt
);

    localparam int unsigned CntWidth = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        C_NONE  = 2'd0,
        C_PAUSE = 2'd1,
        C_BREAK = 2'd2,
        C_HALT  = 2'd3
    } cause_e;

    state_e              st;
    cause_e              cause;
    logic [DivWidth-1:0] div_cnt;
    logic                bp_skip;
    logic                bp_hit;
    logic                tick;

    assign state      = st;
    assign stop_cause = cause;

    // Breakpoint match, run-rate tick and the CPU enable gate.
    // bp_skip masks the breakpoint we just stopped on so a resume retires it.
    always_comb begin
        bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;
        tick   = (div_cnt >= div);
        cpu_en = 1'b0;
        case (st)
            S_RUN:   cpu_en = tick & ~bp_hit & ~cmd_pause & ~halt;
            S_STEP:  cpu_en = ~halt;
            default: cpu_en = 1'b0;
        endcase
    end

    // Control state, stop cause, divider, breakpoint skip and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            cause      <= C_NONE;
            div_cnt    <= '0;
            bp_skip    <= 1'b0;
            inst_cnt   <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (cpu_en) begin
                inst_cnt   <= inst_cnt + CntWidth'(1);
                jump_cnt   <= jump_cnt + CntWidth'(is_jump);
                branch_cnt <= branch_cnt + CntWidth'(is_branch);
                taken_cnt  <= taken_cnt + CntWidth'(branched);
                bp_skip    <= 1'b0;
            end

            // Divider idles at zero outside RUN so every RUN entry starts fresh.
            div_cnt <= '0;

            case (st)
                S_IDLE: begin
                    if (halt) begin
                        st    <= S_HALTED;
                        cause <= C_HALT;
                    end else if (cmd_step) begin
                        st <= S_STEP;
                    end else if (cmd_run) begin
                        st <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        st    <= S_HALTED;
                        cause <= C_HALT;
                    end else if (cmd_pause) begin
                        st    <= S_IDLE;
                        cause <= C_PAUSE;
                    end else if (bp_hit) begin
                        st      <= S_IDLE;
                        cause   <= C_BREAK;
                        bp_skip <= 1'b1;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + DivWidth'(1);
                    end
                end
                S_STEP: begin
                    if (halt) begin
                        st    <= S_HALTED;
                        cause <= C_HALT;
                    end else begin
                        st <= S_IDLE;
                    end
                end
                default: st <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_exec_controller.sv
module tb_syn_exec_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_run = 1'b0, cmd_pause = 1'b0, cmd_step = 1'b0;
    logic [7:0]  div = 8'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        halt = 1'b0, is_jump = 1'b0, is_branch = 1'b0, branched = 1'b0;
    logic        cpu_en;
    logic [1:0]  state, stop_cause;
    logic [31:0] inst_cnt, jump_cnt, branch_cnt, taken_cnt;

    syn_exec_controller #(.DivWidth(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step),
        .div(div), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .halt(halt), .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
        .cpu_en(cpu_en), .state(state), .stop_cause(stop_cause),
        .inst_cnt(inst_cnt), .jump_cnt(jump_cnt),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int dut_pulses = 0;
    logic [31:0] pulse_hist = 32'd0;
    logic [31:0] pc_mask = 32'hFFFF_FFFF;
    logic [31:0] p0;

    // Reference model: mode, last stop reason, cycles waited since last
    // run-rate slot, breakpoint-resume flag, and the four statistics.
    int          m_mode;   // 0 idle, 1 run, 2 step, 3 halted
    int          m_cause;
    int          m_wait;
    bit          m_skip;
    logic [31:0] m_cnt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cause = 0; m_wait = 0; m_skip = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;
    endtask

    function automatic bit model_en();
        bit bp;
        bp = bp_en && (pc == bp_addr) && !m_skip;
        if (halt) return 1'b0;
        if (m_mode == 2) return 1'b1;
        if (m_mode == 1) return (m_wait >= int'(div)) && !bp && !cmd_pause;
        return 1'b0;
    endfunction

    task automatic model_advance(input bit e);
        bit bp;
        bp = bp_en && (pc == bp_addr) && !m_skip;
        if (e) begin
            m_cnt[0] = m_cnt[0] + 32'd1;
            if (is_jump)   m_cnt[1] = m_cnt[1] + 32'd1;
            if (is_branch) m_cnt[2] = m_cnt[2] + 32'd1;
            if (branched)  m_cnt[3] = m_cnt[3] + 32'd1;
            m_skip = 0;
        end
        if (m_mode != 3 && halt) begin
            m_mode = 3; m_cause = 3;
        end else if (m_mode == 0) begin
            if (cmd_step) m_mode = 2;
            else if (cmd_run) begin m_mode = 1; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (cmd_pause) begin m_mode = 0; m_cause = 1; end
            else if (bp) begin m_mode = 0; m_cause = 2; m_skip = 1; end
            else m_wait = (m_wait >= int'(div)) ? 0 : m_wait + 1;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
    endtask

    // One clock: called at a falling edge with inputs set; checks the
    // enable before the rising edge and registered outputs after it.
    task automatic step_cycle();
        bit e;
        #1;
        e = model_en();
        chk("cpu_en", 32'(cpu_en), 32'(e));
        if (cpu_en === 1'b1) dut_pulses++;
        pulse_hist = {pulse_hist[30:0], cpu_en};
        model_advance(e);
        @(posedge clk);
        @(negedge clk);
        chk("state", 32'(state), 32'(m_mode));
        chk("stop_cause", 32'(stop_cause), 32'(m_cause));
        chk("inst_cnt", inst_cnt, m_cnt[0]);
        chk("jump_cnt", jump_cnt, m_cnt[1]);
        chk("branch_cnt", branch_cnt, m_cnt[2]);
        chk("taken_cnt", taken_cnt, m_cnt[3]);
        if (e) pc = (pc + 32'd4) & pc_mask;
        cmd_run = 0; cmd_pause = 0; cmd_step = 0;
        halt = 0; is_jump = 0; is_branch = 0; branched = 0;
    endtask

    // Asynchronous reset pulse away from any clock edge; called at a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cause", 32'(stop_cause), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_inst", inst_cnt, 32'd0);
        chk("rst_jump", jump_cnt, 32'd0);
        chk("rst_branch", branch_cnt, 32'd0);
        chk("rst_taken", taken_cnt, 32'd0);
        model_reset();
        cmd_run = 0; cmd_pause = 0; cmd_step = 0;
        halt = 0; is_jump = 0; is_branch = 0; branched = 0;
        pc = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle after reset release without commands.
        repeat (3) step_cycle();
        chk("idle_hold", 32'(state), 32'd0);

        // Three single steps.
        p0 = 32'(dut_pulses);
        for (int i = 0; i < 3; i++) begin
            cmd_step = 1; step_cycle();
            step_cycle();
            chk("step_back_idle", 32'(state), 32'd0);
        end
        chk("step_pulses", 32'(dut_pulses) - p0, 32'd3);
        chk("step_inst", inst_cnt, 32'd3);

        // div=3 run: enables on RUN cycles 4, 8, 12, 16.
        do_reset();
        div = 8'd3;
        cmd_run = 1; step_cycle();
        repeat (16) step_cycle();
        chk("div3_pattern", {16'd0, pulse_hist[15:0]}, 32'h0000_1111);
        chk("div3_inst", inst_cnt, 32'd4);
        cmd_pause = 1; step_cycle();
        chk("pause_state", 32'(state), 32'd0);
        chk("pause_cause", 32'(stop_cause), 32'd1);

        // Breakpoint at 0x10, then resume through it.
        do_reset();
        div = 8'd0; bp_en = 1; bp_addr = 32'h10; pc = 32'd0;
        cmd_run = 1; step_cycle();
        p0 = 32'(dut_pulses);
        repeat (8) step_cycle();
        chk("bp_pulses", 32'(dut_pulses) - p0, 32'd4);
        chk("bp_state", 32'(state), 32'd0);
        chk("bp_cause", 32'(stop_cause), 32'd2);
        cmd_run = 1; step_cycle();
        step_cycle();
        chk("bp_resume_inst", inst_cnt, 32'd5);
        repeat (3) step_cycle();
        chk("bp_past_inst", inst_cnt, 32'd8);
        chk("bp_past_state", 32'(state), 32'd1);
        chk("bp_cause_held", 32'(stop_cause), 32'd2);
        cmd_pause = 1; step_cycle();
        bp_en = 0;

        // Halt together with pause.
        do_reset();
        div = 8'd0;
        cmd_run = 1; step_cycle();
        step_cycle();
        halt = 1; cmd_pause = 1;
        #1 chk("halt_en_low", 32'(cpu_en), 32'd0);
        step_cycle();
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_cause", 32'(stop_cause), 32'd3);
        p0 = 32'(dut_pulses);
        cmd_run = 1; step_cycle();
        cmd_step = 1; step_cycle();
        repeat (3) step_cycle();
        chk("halted_no_en", 32'(dut_pulses) - p0, 32'd0);
        chk("halted_stays", 32'(state), 32'd3);

        // Statistics with mixed status bits.
        do_reset();
        div = 8'd0;
        cmd_run = 1; step_cycle();
        for (int i = 0; i < 5; i++) begin
            is_branch = (i < 3);
            branched  = (i < 2);
            is_jump   = (i == 3);
            step_cycle();
        end
        cmd_pause = 1; step_cycle();
        chk("stat_inst", inst_cnt, 32'd5);
        chk("stat_branch", branch_cnt, 32'd3);
        chk("stat_taken", taken_cnt, 32'd2);
        chk("stat_jump", jump_cnt, 32'd1);

        // Counter wrap from a preset value, then reset mid-RUN.
        do_reset();
        force dut.inst_cnt = 32'hFFFF_FFFF;
        #1 release dut.inst_cnt;
        m_cnt[0] = 32'hFFFF_FFFF;
        cmd_step = 1; step_cycle();
        step_cycle();
        chk("wrap_inst", inst_cnt, 32'd0);
        div = 8'd1;
        cmd_run = 1; step_cycle();
        repeat (5) step_cycle();
        do_reset();

        // Randomized episodes against the model.
        pc_mask = 32'h0000_003F;
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            div = 8'($urandom_range(0, 4));
            for (int c = 0; c < 400; c++) begin
                cmd_run   = ($urandom_range(0, 9) == 0);
                cmd_pause = ($urandom_range(0, 11) == 0);
                cmd_step  = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 4));
                if ($urandom_range(0, 29) == 0) begin
                    bp_en   = 1'($urandom_range(0, 1));
                    bp_addr = 32'($urandom_range(0, 15)) << 2;
                end
                halt      = ($urandom_range(0, 399) == 0);
                is_jump   = 1'($urandom_range(0, 1));
                is_branch = 1'($urandom_range(0, 1));
                branched  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) pc = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 249) == 0) do_reset();
                else step_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/syn_exec_controller.md
SYN_EXEC_CONTROLLER -- requirements
Module: syn_exec_controller

Interface
REQ-001 SHALL have parameter DivWidth, default 8, width of the run-speed divisor.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports cmd_run, cmd_pause, cmd_step  input  1 each  single-cycle command pulses, already debounced.
REQ-005 SHALL have port div  input  DivWidth  run-mode divisor; CPU enabled once every div+1 cycles.
REQ-006 SHALL have ports bp_en  input  1  and bp_addr  input  32  breakpoint enable and instruction address.
REQ-007 SHALL have port pc  input  32  current CPU PC (CPU pc_dbg).
REQ-008 SHALL have ports halt, is_jump, is_branch, branched  input  1 each  CPU status for the current instruction.
REQ-009 SHALL have port cpu_en  output  1  CPU enable; one high cycle retires exactly one instruction.
REQ-010 SHALL have port state  output  2  IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-011 SHALL have port stop_cause  output  2  NONE=0, PAUSE=1, BREAK=2, HALT=3.
REQ-012 SHALL have ports inst_cnt, jump_cnt, branch_cnt, taken_cnt  output  32 each  statistics counters.

Function
REQ-013 cpu_en SHALL be combinational from registered state and current inputs; all other outputs SHALL be registered.
REQ-014 cpu_en SHALL be 0 whenever halt=1 or state is IDLE or HALTED.
REQ-015 bp_hit SHALL be bp_en & (pc==bp_addr) & ~bp_skip; bp_skip is an internal flag.
REQ-016 IDLE: cmd_step -> STEP; else cmd_run -> RUN; cmd_pause ignored; both step and run -> STEP.
REQ-017 STEP: cpu_en=1 for exactly that cycle regardless of bp_hit; next state IDLE.
REQ-018 RUN: div_cnt (DivWidth bits) SHALL be 0 on entry and increment every RUN cycle; tick = (div_cnt >= div), after which div_cnt returns to 0.
REQ-019 RUN: cpu_en = tick & ~bp_hit & ~cmd_pause & ~halt; div=0 gives cpu_en every cycle, including the first RUN cycle.
REQ-020 RUN: cmd_pause -> IDLE, stop_cause=PAUSE; else bp_hit -> IDLE, stop_cause=BREAK, bp_skip<=1 (checked every cycle, not only on tick); cmd_run/cmd_step ignored.
REQ-021 bp_skip SHALL clear on any cycle with cpu_en=1, so resuming from a breakpoint executes the instruction at bp_addr once.
REQ-022 halt=1 in IDLE, RUN or STEP SHALL force next state HALTED, stop_cause=HALT, with priority over all commands and breakpoints.
REQ-023 HALTED SHALL be left only by reset; all commands ignored.
REQ-024 On each cpu_en=1 cycle: inst_cnt+1; jump_cnt+1 if is_jump; branch_cnt+1 if is_branch; taken_cnt+1 if branched.
REQ-025 Counters SHALL wrap modulo 2^32 without saturation or flag.
REQ-026 Changing div mid-RUN SHALL take effect on the next compare; no glitch beyond the >= rule.
REQ-027 stop_cause SHALL hold its value until the next stop event; entering RUN or STEP does not clear it.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, cpu_en=0, stop_cause=NONE, div_cnt=0, bp_skip=0, and all counters to 0, including mid-RUN or mid-STEP.
REQ-029 After rst_n release, the block SHALL stay IDLE until a command pulse.

Verification
REQ-030 Reset, cmd_step x3, no branches -> three single cpu_en pulses, state returns to 0 each time, inst_cnt=3.
REQ-031 div=3, cmd_run, 16 cycles -> cpu_en high on RUN cycles 4, 8, 12, 16 (1-based), inst_cnt=4; cmd_pause then gives state=0, stop_cause=1.
REQ-032 bp_en=1, bp_addr=0x0000_0010, div=0, run from pc=0 (+4 per step) -> 4 cpu_en pulses, state=0, stop_cause=2; cmd_run -> the instruction at 0x10 retires, and run continues past it.
REQ-033 halt asserted in RUN simultaneously with cmd_pause -> cpu_en=0 that cycle, state=3, stop_cause=3; later cmd_run/cmd_step produce no cpu_en.
REQ-034 div=0, 5 enabled cycles with is_branch=1 on 3 of them, branched=1 on 2, is_jump=1 on 1 -> inst_cnt=5, branch_cnt=3, taken_cnt=2, jump_cnt=1.
REQ-035 Counter preset 0xFFFF_FFFF via forced state, one step -> inst_cnt=0; rst_n pulse mid-RUN -> all outputs 0 asynchronously.
